// File: rtl/jtag_1149_d10_crc_frame_ctrl.sv
// Frame-level sequencer in front of the 1149.10 CRC32 LFSR engine.
// Forwards data words to the engine and checks the trailing received-CRC word
// against the engine's running CRC. Clears the engine between frames and
// reports per-frame pass/fail and protocol errors.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | waiting for a first (sop) data word; non-sop words dropped
// S_DATA       | inside a frame, forwarding data words to the engine
// S_CHECK      | one cycle: report result, clear engine
// S_CHECK_ABRT | one cycle: clear engine after an unexpected sop, no report
// S_DROP       | frame broken, discard words until the CRC (eop) word
module jtag_1149_d10_crc_frame_ctrl #(
    parameter logic [15:0] MAX_WORDS = 16'd1024,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic [3:0]       in_be,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic             crc_valid,
    output logic [3:0]       crc_be,
    output logic             crc_eop,
    output logic [31:0]      crc_data,
    input  logic [31:0]      crc_in,
    output logic             frame_done,
    output logic             frame_crc_ok,
    output logic [CNT_W-1:0] frame_len,
    output logic             proto_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_CHECK,
        S_CHECK_ABRT,
        S_DROP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_word_cnt;
    logic [CNT_W-1:0] w_word_cnt_nxt;
    logic             r_ok;
    logic             w_ok_nxt;
    logic [CNT_W-1:0] r_frame_len;
    logic [CNT_W-1:0] r_err_cnt;
    logic             w_accept;
    logic             w_be_legal;
    logic             w_fwd;
    logic             w_err_inc;

    // The two report states are the only cycles where input is stalled.
    assign in_ready   = (r_state != S_CHECK) && (r_state != S_CHECK_ABRT);
    assign w_accept   = in_valid & in_ready;
    assign w_be_legal = (in_be == 4'b1111) || (in_be == 4'b1110) ||
                        (in_be == 4'b1100) || (in_be == 4'b1000);

    // Next-state and per-cycle outputs. Within DATA: sop beats eop, and eop
    // beats the length and byte-enable checks.
    always_comb begin
        w_state_nxt    = r_state;
        w_word_cnt_nxt = r_word_cnt;
        w_ok_nxt       = r_ok;
        w_fwd          = 1'b0;
        crc_eop        = 1'b0;
        frame_done     = 1'b0;
        frame_crc_ok   = 1'b0;
        proto_err      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && in_sop) begin
                    if (in_eop) begin
                        proto_err = 1'b1;
                    end else begin
                        w_fwd          = 1'b1;
                        w_word_cnt_nxt = CNT_W'(1);
                        w_state_nxt    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    if (in_sop) begin
                        proto_err   = 1'b1;
                        w_state_nxt = S_CHECK_ABRT;
                    end else if (in_eop) begin
                        // crc_in already includes the last data word.
                        w_ok_nxt    = (in_data == crc_in);
                        w_state_nxt = S_CHECK;
                    end else if (r_word_cnt == MAX_CNT || !w_be_legal) begin
                        proto_err   = 1'b1;
                        w_state_nxt = S_DROP;
                    end else begin
                        w_fwd          = 1'b1;
                        w_word_cnt_nxt = r_word_cnt + CNT_W'(1);
                    end
                end
            end
            S_CHECK: begin
                crc_eop      = 1'b1;
                frame_done   = 1'b1;
                frame_crc_ok = r_ok;
                w_state_nxt  = S_IDLE;
            end
            S_CHECK_ABRT: begin
                crc_eop     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_DROP: begin
                if (w_accept && in_eop) begin
                    crc_eop     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign crc_valid = w_fwd;
    assign crc_data  = w_fwd ? in_data : 32'd0;
    assign crc_be    = w_fwd ? in_be : 4'd0;
    assign w_err_inc = proto_err | (frame_done & ~r_ok);
    assign frame_len = r_frame_len;
    assign err_cnt   = r_err_cnt;

    // State, word counter and latched compare result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_word_cnt <= '0;
            r_ok       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_ok       <= w_ok_nxt;
        end
    end

    // Frame length of the last reported frame and saturating error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_len <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (r_state == S_CHECK) begin
                r_frame_len <= r_word_cnt;
            end
            if (w_err_inc && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_jtag_1149_d10_crc_frame_ctrl.sv
// Bench for jtag_1149_d10_crc_frame_ctrl: directed frames followed by random
// frames, each judged by frame kind against expected counts of events.
module tb_jtag_1149_d10_crc_frame_ctrl;

    localparam int          CNT_W = 3;
    localparam int          MAX   = 4;
    localparam logic [15:0] MAXW  = 16'd4;
    localparam logic [31:0] POLY  = 32'h04C11DB7;

    localparam int K_GOOD  = 0;
    localparam int K_BAD   = 1;
    localparam int K_ZERO  = 2;
    localparam int K_ABORT = 3;
    localparam int K_LONG  = 4;
    localparam int K_BE    = 5;
    localparam int K_STRAY = 6;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [3:0]       in_be;
    logic             in_sop;
    logic             in_eop;
    logic             crc_valid;
    logic [3:0]       crc_be;
    logic             crc_eop;
    logic [31:0]      crc_data;
    logic [31:0]      crc_in;
    logic             frame_done;
    logic             frame_crc_ok;
    logic [CNT_W-1:0] frame_len;
    logic             proto_err;
    logic [CNT_W-1:0] err_cnt;

    jtag_1149_d10_crc_frame_ctrl #(.MAX_WORDS(MAXW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_be(in_be),
        .in_sop(in_sop), .in_eop(in_eop),
        .crc_valid(crc_valid), .crc_be(crc_be), .crc_eop(crc_eop), .crc_data(crc_data),
        .crc_in(crc_in),
        .frame_done(frame_done), .frame_crc_ok(frame_crc_ok), .frame_len(frame_len),
        .proto_err(proto_err), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {b, 24'd0};
        for (int k = 0; k < 8; k++) r = r[31] ? ((r << 1) ^ POLY) : (r << 1);
        return r;
    endfunction

    function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] d,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = c;
        for (int b = 3; b >= 0; b--) if (be[b]) r = crc_byte(r, d[8*b +: 8]);
        return r;
    endfunction

    // Engine stand-in: registered running CRC, MSB byte first, cleared by eop.
    logic [31:0] eng;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         eng <= 32'd0;
        else if (crc_eop)   eng <= 32'd0;
        else if (crc_valid) eng <= crc_word(eng, crc_data, crc_be);
    end
    assign crc_in = eng;

    logic [31:0] w_data [0:7];
    logic [3:0]  w_be   [0:7];

    function automatic logic [3:0] legal_be(input int sel);
        case (sel % 4)
            0:       return 4'b1111;
            1:       return 4'b1110;
            2:       return 4'b1100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [3:0] illegal_be();
        logic [3:0] v;
        v = 4'b1111;
        while (v == 4'b1111 || v == 4'b1110 || v == 4'b1100 || v == 4'b1000) v = 4'($urandom);
        return v;
    endfunction

    task automatic gen_words(input int n);
        for (int i = 0; i < n; i++) begin
            w_data[i] = $urandom;
            w_be[i]   = legal_be(int'($urandom_range(0, 3)));
        end
    endtask

    // Reference CRC of a frame: the enabled bytes flattened into one stream.
    function automatic logic [31:0] ref_crc(input int n);
        logic [7:0]  q[$];
        logic [31:0] c;
        c = 32'd0;
        for (int i = 0; i < n; i++)
            for (int b = 3; b >= 0; b--)
                if (w_be[i][b]) q.push_back(w_data[i][8*b +: 8]);
        foreach (q[k]) c = crc_byte(c, q[k]);
        return c;
    endfunction

    int n_done, n_ok, n_perr, n_eop, n_valid, n_stall, inv_bad;
    logic last_ready;
    int exp_err, exp_len;

    task automatic clear_obs();
        n_done = 0; n_ok = 0; n_perr = 0; n_eop = 0; n_valid = 0; n_stall = 0; inv_bad = 0;
    endtask

    task automatic tick();
        @(negedge clk);
        last_ready = in_ready;
        if (crc_valid) n_valid++;
        if (crc_eop) n_eop++;
        if (proto_err) n_perr++;
        if (in_valid && !in_ready) n_stall++;
        if (frame_done) begin
            n_done++;
            if (frame_crc_ok) n_ok++;
        end
        if ((crc_valid && crc_eop) || (frame_crc_ok && !frame_done)) inv_bad++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] be, input logic sop,
                             input logic eop);
        int t;
        in_valid = 1'b1; in_data = d; in_be = be; in_sop = sop; in_eop = eop;
        t = 0;
        do begin
            tick();
            t++;
        end while (!last_ready && t < 8);
        chk("handshake", {31'd0, last_ready}, 32'd1);
    endtask

    task automatic idle(input int k);
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        repeat (k) tick();
    endtask

    task automatic play(input int kind, input int n, input int p, input logic [31:0] crcw,
                        input bit gaps);
        case (kind)
            K_ZERO:  send_word($urandom, 4'b1111, 1'b1, 1'b1);
            K_STRAY: send_word($urandom, legal_be(int'($urandom_range(0, 3))), 1'b0,
                               1'($urandom_range(0, 1)));
            default: begin
                for (int i = 0; i < n; i++) begin
                    if (gaps && i > 0 && $urandom_range(0, 3) == 0) idle(1);
                    send_word(w_data[i], (kind == K_BE && i == p) ? illegal_be() : w_be[i],
                              i == 0, 1'b0);
                end
                if (kind == K_ABORT) send_word($urandom, 4'b1111, 1'b1, 1'b0);
                else                 send_word(crcw, 4'($urandom), 1'b0, 1'b1);
            end
        endcase
    endtask

    task automatic expect_frame(input string tag, input int kind, input int n, input int p);
        int e_done, e_ok, e_perr, e_eop, e_valid, e_inc;
        e_done = 0; e_ok = 0; e_perr = 0; e_eop = 0; e_valid = 0; e_inc = 0;
        case (kind)
            K_GOOD:  begin e_done = 1; e_ok = 1; e_eop = 1; e_valid = n; end
            K_BAD:   begin e_done = 1; e_eop = 1; e_valid = n; e_inc = 1; end
            K_ZERO:  begin e_perr = 1; e_inc = 1; end
            K_ABORT: begin e_perr = 1; e_eop = 1; e_valid = n; e_inc = 1; end
            K_LONG:  begin e_perr = 1; e_eop = 1; e_valid = MAX; e_inc = 1; end
            K_BE:    begin e_perr = 1; e_eop = 1; e_valid = p; e_inc = 1; end
            default: ;
        endcase
        if (e_done != 0) exp_len = n;
        exp_err = (exp_err + e_inc > 7) ? 7 : exp_err + e_inc;
        chk({tag, ".done"},  n_done,  e_done);
        chk({tag, ".ok"},    n_ok,    e_ok);
        chk({tag, ".perr"},  n_perr,  e_perr);
        chk({tag, ".eop"},   n_eop,   e_eop);
        chk({tag, ".valid"}, n_valid, e_valid);
        chk({tag, ".len"},   {29'd0, frame_len}, exp_len);
        chk({tag, ".errcnt"}, {29'd0, err_cnt}, exp_err);
        chk({tag, ".invariant"}, inv_bad, 0);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, ".ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, ".flags"}, {27'd0, crc_valid, crc_eop, frame_done, frame_crc_ok, proto_err}, 0);
        chk({tag, ".len"}, {29'd0, frame_len}, 0);
        chk({tag, ".errcnt"}, {29'd0, err_cnt}, 0);
        chk({tag, ".crcdata"}, crc_data, 0);
        chk({tag, ".crcbe"}, {28'd0, crc_be}, 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_data = 32'd0; in_be = 4'd0; in_sop = 1'b0; in_eop = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_err = 0;
        exp_len = 0;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, n, p;
        logic [31:0] c1, c2;
        int n1, n2;

        do_reset();
        reset_check("reset");
        @(posedge clk); #1;

        // 1: single word whose CRC equals the polynomial
        w_data[0] = 32'h00000001; w_be[0] = 4'b1111;
        clear_obs(); play(K_GOOD, 1, 0, 32'h04C11DB7, 1'b0); idle(3);
        expect_frame("t1", K_GOOD, 1, 0);

        // 2: same frame, corrupted CRC
        clear_obs(); play(K_BAD, 1, 0, 32'h04C11DB6, 1'b0); idle(3);
        expect_frame("t2", K_BAD, 1, 0);

        // 3: sop and eop on the same word
        clear_obs(); play(K_ZERO, 0, 0, 32'd0, 1'b0); idle(3);
        expect_frame("t3", K_ZERO, 0, 0);

        // 4: sop after 3 data words, then a clean frame
        gen_words(3);
        clear_obs(); play(K_ABORT, 3, 0, 32'd0, 1'b0); idle(3);
        expect_frame("t4a", K_ABORT, 3, 0);
        gen_words(3); c1 = ref_crc(3);
        clear_obs(); play(K_GOOD, 3, 0, c1, 1'b0); idle(3);
        expect_frame("t4b", K_GOOD, 3, 0);

        // 5: one data word past the limit
        gen_words(5);
        clear_obs(); play(K_LONG, 5, 0, 32'd0, 1'b0); idle(3);
        expect_frame("t5", K_LONG, 5, 0);

        // 6: two back-to-back frames with in_valid held, then a stray word
        n1 = 4; gen_words(n1); c1 = ref_crc(n1);
        clear_obs();
        play(K_GOOD, n1, 0, c1, 1'b0);
        n2 = 2; gen_words(n2); c2 = ref_crc(n2);
        play(K_GOOD, n2, 0, c2, 1'b0);
        send_word(32'hDEADBEEF, 4'b1111, 1'b0, 1'b0);
        idle(3);
        chk("t6.done",  n_done, 2);
        chk("t6.ok",    n_ok, 2);
        chk("t6.valid", n_valid, n1 + n2);
        chk("t6.eop",   n_eop, 2);
        chk("t6.stall", n_stall, 2);
        chk("t6.len",   {29'd0, frame_len}, n2);
        exp_len = n2;

        // 6b: be=0101 on the third word
        gen_words(4); w_be[2] = 4'b0101;
        clear_obs();
        for (int i = 0; i < 4; i++) send_word(w_data[i], w_be[i], i == 0, 1'b0);
        send_word(32'h12345678, 4'b0000, 1'b0, 1'b1);
        idle(3);
        expect_frame("t6b", K_BE, 4, 2);

        // Counter saturation after several further errors
        for (int i = 0; i < 3; i++) begin
            clear_obs(); play(K_ZERO, 0, 0, 32'd0, 1'b0); idle(2);
            expect_frame("sat", K_ZERO, 0, 0);
        end

        // Random frames from a fresh reset
        do_reset();
        reset_check("reset2");
        @(posedge clk); #1;
        for (int f = 0; f < 60; f++) begin
            kind = int'($urandom_range(0, 6));
            p = 0;
            case (kind)
                K_LONG:  n = int'($urandom_range(MAX + 1, MAX + 2));
                K_BE:    begin n = int'($urandom_range(2, MAX)); p = int'($urandom_range(1, n - 1)); end
                K_ZERO, K_STRAY: n = 0;
                default: n = int'($urandom_range(1, MAX));
            endcase
            gen_words(n);
            c1 = ref_crc(n);
            if (kind == K_BAD) c1 = c1 ^ (32'd1 << $urandom_range(0, 31));
            clear_obs();
            play(kind, n, p, c1, 1'b1);
            idle(int'($urandom_range(2, 3)));
            expect_frame($sformatf("rnd%0d", f), kind, n, p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
